// File: rtl/aes_kat_sequencer.sv
// Known-answer-test sequencer: walks NUM_VECTORS {plaintext, key, expected} ROM entries through
// an AES core, compares each ciphertext and reports pass/fail, first failing index and timeouts.
module aes_kat_sequencer #(
  parameter int KEY_BITS    = 256,
  parameter int NUM_VECTORS = 2,
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT     = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [127:0]        rom_in,
  input  logic [KEY_BITS-1:0] rom_key,
  input  logic [127:0]        rom_expected,
  output logic                core_start,
  output logic [127:0]        core_in,
  output logic [KEY_BITS-1:0] core_key,
  input  logic                core_done,
  input  logic [127:0]        core_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                led,
  output logic [8:0]          fail_count,
  output logic [ADDR_W-1:0]   first_fail_idx,
  output logic                timeout_flag,
  output logic [2:0]          state_dbg
);

  if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
    $error("aes_kat_sequencer: KEY_BITS must be 128, 192 or 256");
  end
  if (NUM_VECTORS < 1 || NUM_VECTORS > 256 || (2 ** ADDR_W) < NUM_VECTORS) begin : g_bad_vectors
    $error("aes_kat_sequencer: NUM_VECTORS must be 1..256 and fit in ADDR_W");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("aes_kat_sequencer: TIMEOUT must be >= 2");
  end

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_VECTORS - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_ROM_WAIT  = 3'd2;
  localparam logic [2:0] S_LAUNCH    = 3'd3;
  localparam logic [2:0] S_WAIT_CORE = 3'd4;
  localparam logic [2:0] S_COMPARE   = 3'd5;
  localparam logic [2:0] S_FINISH    = 3'd6;

  logic [2:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [TMR_W-1:0]  timer;
  logic [127:0]      exp_reg;
  logic [127:0]      result;
  logic              timed_out;
  logic              mismatch;

  // Core handshake: core_start is a one-cycle request; core_in/core_key stay put until the core
  // answers with a one-cycle core_done, which is only honoured while waiting in WAIT_CORE.
  assign core_start = (state == S_LAUNCH);
  assign done       = (state == S_FINISH);
  assign led        = pass;
  assign state_dbg  = state;
  assign mismatch   = timed_out || (result != exp_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      idx            <= '0;
      timer          <= '0;
      exp_reg        <= '0;
      result         <= '0;
      timed_out      <= 1'b0;
      rom_addr       <= '0;
      core_in        <= '0;
      core_key       <= '0;
      busy           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= '0;
      first_fail_idx <= '1;
      timeout_flag   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy           <= 1'b1;
            idx            <= '0;
            fail_count     <= '0;
            pass           <= 1'b0;
            timeout_flag   <= 1'b0;
            first_fail_idx <= '1;
            state          <= S_FETCH;
          end
        end
        S_FETCH: begin
          rom_addr <= idx;
          state    <= S_ROM_WAIT;
        end
        S_ROM_WAIT: begin
          core_in  <= rom_in;
          core_key <= rom_key;
          exp_reg  <= rom_expected;
          state    <= S_LAUNCH;
        end
        S_LAUNCH: begin
          timer     <= '0;
          timed_out <= 1'b0;
          state     <= S_WAIT_CORE;
        end
        S_WAIT_CORE: begin
          // A core_done arriving on the last allowed cycle still counts as a real answer.
          if (core_done) begin
            result <= core_out;
            state  <= S_COMPARE;
          end else if (timer == TMR_LAST) begin
            timeout_flag <= 1'b1;
            timed_out    <= 1'b1;
            state        <= S_COMPARE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_COMPARE: begin
          if (mismatch) begin
            if (fail_count != 9'h1ff) fail_count <= fail_count + 9'd1;
            if (fail_count == 9'd0) first_fail_idx <= idx;
          end
          if (idx == IDX_LAST) begin
            state <= S_FINISH;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_FETCH;
          end
        end
        S_FINISH: begin
          busy  <= 1'b0;
          pass  <= (fail_count == 9'd0);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_kat_sequencer.sv
// Bench for aes_kat_sequencer: a 256-bit-key instance driven by directed and random runs against a
// run-level reference model, plus a 128-bit-key single-vector instance for the AES-128 KAT.
module tb_aes_kat_sequencer;

  localparam int NV = 2;
  localparam int TO = 64;
  localparam logic [127:0] KAT_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KAT_K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KAT_C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] KAT_K128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KAT_C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- core stand-ins ----------------
  // Real AES answers for the known vectors, an arbitrary keyed mix for everything else.
  function automatic logic [127:0] stub256(logic [127:0] pt, logic [255:0] k);
    if (pt == KAT_PT && k == KAT_K256) return KAT_C256;
    return {pt[63:0], pt[127:64]} ^ k[255:128] ^ k[127:0] ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
  endfunction

  function automatic logic [127:0] stub128(logic [127:0] pt, logic [127:0] k);
    if (pt == KAT_PT && k == KAT_K128) return KAT_C128;
    return pt ^ k;
  endfunction

  // ---------------- 256-bit instance ----------------
  logic         a_start = 1'b0;
  logic [7:0]   a_rom_addr;
  logic [127:0] a_rom_in, a_rom_expected, a_core_in, a_core_out;
  logic [255:0] a_rom_key, a_core_key;
  logic         a_core_start, a_core_done, a_busy, a_done, a_pass, a_led, a_tflag;
  logic [8:0]   a_fail_count;
  logic [7:0]   a_ffi;
  logic [2:0]   a_state_dbg;

  logic [127:0] pt_mem  [256];
  logic [255:0] key_mem [256];
  logic [127:0] exp_mem [256];
  int           lat_mem [256];
  logic         mute = 1'b0;
  logic         inject_done = 1'b0;
  int           a_cnt;

  assign a_rom_in       = pt_mem[a_rom_addr];
  assign a_rom_key      = key_mem[a_rom_addr];
  assign a_rom_expected = exp_mem[a_rom_addr];

  always @(posedge clk) begin
    if (rst) a_cnt <= 0;
    else if (a_core_start) a_cnt <= lat_mem[a_rom_addr];
    else if (a_cnt != 0) a_cnt <= a_cnt - 1;
  end
  assign a_core_done = (a_cnt == 1 && !mute) || inject_done;
  assign a_core_out  = inject_done ? ~stub256(a_core_in, a_core_key) : stub256(a_core_in, a_core_key);

  int n_core_start = 0;
  int n_done = 0;
  always @(posedge clk) begin
    if (a_core_start) n_core_start <= n_core_start + 1;
    if (a_done) n_done <= n_done + 1;
  end

  aes_kat_sequencer #(.KEY_BITS(256), .NUM_VECTORS(NV), .ADDR_W(8), .TIMEOUT(TO)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .rom_addr(a_rom_addr), .rom_in(a_rom_in),
    .rom_key(a_rom_key), .rom_expected(a_rom_expected), .core_start(a_core_start),
    .core_in(a_core_in), .core_key(a_core_key), .core_done(a_core_done), .core_out(a_core_out),
    .busy(a_busy), .done(a_done), .pass(a_pass), .led(a_led), .fail_count(a_fail_count),
    .first_fail_idx(a_ffi), .timeout_flag(a_tflag), .state_dbg(a_state_dbg)
  );

  // ---------------- 128-bit single-vector instance ----------------
  logic         b_start = 1'b0;
  logic [1:0]   b_rom_addr, b_ffi;
  logic [127:0] b_rom_in, b_rom_key, b_rom_expected, b_core_in, b_core_key, b_core_out;
  logic         b_core_start, b_core_done, b_busy, b_done, b_pass, b_led, b_tflag;
  logic [8:0]   b_fail_count;
  logic [2:0]   b_state_dbg;
  logic [127:0] b_exp = '0;
  int           b_lat = 1;
  int           b_cnt;

  assign b_rom_in       = KAT_PT;
  assign b_rom_key      = KAT_K128;
  assign b_rom_expected = b_exp;
  always @(posedge clk) begin
    if (rst) b_cnt <= 0;
    else if (b_core_start) b_cnt <= b_lat;
    else if (b_cnt != 0) b_cnt <= b_cnt - 1;
  end
  assign b_core_done = (b_cnt == 1);
  assign b_core_out  = stub128(b_core_in, b_core_key);

  aes_kat_sequencer #(.KEY_BITS(128), .NUM_VECTORS(1), .ADDR_W(2), .TIMEOUT(4)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .rom_addr(b_rom_addr), .rom_in(b_rom_in),
    .rom_key(b_rom_key), .rom_expected(b_rom_expected), .core_start(b_core_start),
    .core_in(b_core_in), .core_key(b_core_key), .core_done(b_core_done), .core_out(b_core_out),
    .busy(b_busy), .done(b_done), .pass(b_pass), .led(b_led), .fail_count(b_fail_count),
    .first_fail_idx(b_ffi), .timeout_flag(b_tflag), .state_dbg(b_state_dbg)
  );

  // ---------------- checking helpers ----------------
  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_vec(int i, logic [127:0] pt, logic [255:0] k, int flip_bit, int lat);
    logic [127:0] e;
    e = stub256(pt, k);
    if (flip_bit >= 0) e[flip_bit] = ~e[flip_bit];
    pt_mem[i] = pt; key_mem[i] = k; exp_mem[i] = e; lat_mem[i] = lat;
  endtask

  // Run-level reference: outcome of a whole run from the vector table and the core's behaviour.
  task automatic model_run(output int fc, output int ffi, output bit tf, output int len);
    bit timed, bad;
    fc = 0; ffi = 255; tf = 1'b0; len = 1;
    for (int i = 0; i < NV; i++) begin
      timed = mute || (lat_mem[i] > TO);
      bad   = timed || (stub256(pt_mem[i], key_mem[i]) != exp_mem[i]);
      len  += 4 + (timed ? TO : lat_mem[i]);
      if (timed) tf = 1'b1;
      if (bad) begin
        if (fc == 0) ffi = i;
        if (fc < 511) fc++;
      end
    end
  endtask

  // Called positioned at a negedge in IDLE; returns at the negedge after the FINISH cycle.
  task automatic run_a(string tag, bit busy_start, bit finish_start);
    int fc, ffi, len, cs, n, s0, d0;
    bit tf;
    model_run(fc, ffi, tf, len);
    s0 = n_core_start; d0 = n_done;
    a_start = 1'b1; cs = cyc;
    @(negedge clk); a_start = 1'b0;
    chk({tag, ":busy_up"}, a_busy, 1);
    chk({tag, ":pass_clr"}, {a_pass, a_led, a_tflag, a_fail_count, a_ffi}, {3'b000, 9'd0, 8'hff});
    n = 0;
    while (!a_done && n < 2000) begin
      @(negedge clk); n++;
      a_start = busy_start && (n == 3);
    end
    chk({tag, ":done_seen"}, a_done, 1);
    chk({tag, ":run_len"}, cyc - cs, len);
    a_start = finish_start;
    @(negedge clk); a_start = 1'b0;
    chk({tag, ":busy_down"}, a_busy, 0);
    chk({tag, ":pass"}, {a_pass, a_led}, {2{fc == 0}});
    chk({tag, ":fail_count"}, a_fail_count, fc);
    chk({tag, ":first_fail"}, a_ffi, ffi);
    chk({tag, ":timeout"}, a_tflag, tf);
    chk({tag, ":launches"}, n_core_start - s0, NV);
    chk({tag, ":one_done"}, n_done - d0, 1);
  endtask

  task automatic run_b(string tag, int lat, logic [127:0] expv);
    int cs, n, len;
    bit tmo, bad;
    b_lat = lat; b_exp = expv;
    tmo = lat > 4;
    bad = tmo || (stub128(KAT_PT, KAT_K128) != expv);
    len = 4 + (tmo ? 4 : lat) + 1;
    b_start = 1'b1; cs = cyc;
    @(negedge clk); b_start = 1'b0;
    n = 0;
    while (!b_done && n < 200) begin @(negedge clk); n++; end
    chk({tag, ":done_seen"}, b_done, 1);
    chk({tag, ":run_len"}, cyc - cs, len);
    @(negedge clk);
    chk({tag, ":pass"}, {b_pass, b_led}, {2{!bad}});
    chk({tag, ":fail_count"}, b_fail_count, bad);
    chk({tag, ":first_fail"}, b_ffi, bad ? 2'd0 : 2'd3);
    chk({tag, ":timeout"}, b_tflag, tmo);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, s0, d0, lat_pick;
    logic [127:0] rpt;
    logic [255:0] rkey;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset:a_outs", {a_busy, a_done, a_pass, a_led, a_tflag, a_core_start, a_fail_count, a_ffi},
        {6'b0, 9'd0, 8'hff});
    chk("reset:a_ports", {a_rom_addr, a_core_in}, '0);
    chk("reset:b_outs", {b_busy, b_done, b_pass, b_led, b_tflag, b_fail_count, b_ffi}, {5'b0, 9'd0, 2'b11});

    // AES-256 known answer on both vectors
    set_vec(0, KAT_PT, KAT_K256, -1, 3);
    set_vec(1, KAT_PT, KAT_K256, -1, 5);
    run_a("kat256", 1'b0, 1'b0);

    // second vector's expected value has bit 0 flipped; started the cycle after done
    set_vec(1, KAT_PT, KAT_K256, 0, 2);
    run_a("flip1", 1'b0, 1'b0);

    // core never answers
    mute = 1'b1;
    run_a("mute", 1'b0, 1'b0);
    mute = 1'b0;

    // latency exactly at the limit is accepted, one past it times out
    set_vec(0, KAT_PT, KAT_K256, -1, TO);
    set_vec(1, KAT_PT, KAT_K256, -1, TO + 1);
    run_a("edge_to", 1'b0, 1'b0);

    // start while busy and during FINISH, then a stray core_done in IDLE
    set_vec(0, KAT_PT, KAT_K256, -1, 4);
    set_vec(1, KAT_PT, KAT_K256, -1, 4);
    run_a("ign_start", 1'b1, 1'b1);
    inject_done = 1'b1;
    @(negedge clk); inject_done = 1'b0;
    @(negedge clk);
    chk("idle_inject", {a_busy, a_pass, a_fail_count, a_ffi}, {2'b01, 9'd0, 8'hff});
    run_a("after_inject", 1'b0, 1'b0);

    // reset in the middle of the first vector's core wait
    set_vec(0, KAT_PT, KAT_K256, -1, 20);
    d0 = n_done; s0 = n_core_start;
    a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    n = 0;
    while (n_core_start == s0 && n < 50) begin @(negedge clk); n++; end
    chk("rst_mid:launched", n_core_start - s0, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_mid:outs", {a_busy, a_done, a_pass, a_tflag, a_fail_count, a_ffi}, {4'b0, 9'd0, 8'hff});
    chk("rst_mid:no_done", n_done - d0, 0);
    set_vec(0, KAT_PT, KAT_K256, -1, 3);
    run_a("rst_mid:rerun", 1'b0, 1'b0);

    // randomized runs
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < NV; i++) begin
        rpt  = {$urandom, $urandom, $urandom, $urandom};
        rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 3) == 0) begin rpt = KAT_PT; rkey = KAT_K256; end
        lat_pick = $urandom_range(0, 9);
        set_vec(i, rpt, rkey, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 127)) : -1,
                (lat_pick == 7) ? TO : (lat_pick == 8) ? TO + 1 : (lat_pick == 9) ? TO - 1
                                 : int'($urandom_range(1, 10)));
      end
      mute = ($urandom_range(0, 9) == 0);
      run_a($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      mute = 1'b0;
    end

    // AES-128 known answer, latency boundaries around TIMEOUT=4, and a wrong expected value
    run_b("kat128", 3, KAT_C128);
    run_b("kat128_lat4", 4, KAT_C128);
    run_b("kat128_tmo", 5, KAT_C128);
    run_b("kat128_bad", 2, KAT_C128 ^ 128'h1);
    run_b("kat128_again", 1, KAT_C128);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
